// File: rtl/vga_timing_pkg.sv
// Shared VGA timing types, standard mode presets and the total-length helper.
package vga_timing_pkg;

    typedef struct packed {
        logic [15:0] h_visible;
        logic [15:0] h_front;
        logic [15:0] h_sync;
        logic [15:0] h_back;
        logic [15:0] v_visible;
        logic [15:0] v_front;
        logic [15:0] v_sync;
        logic [15:0] v_back;
        logic        h_pol;
        logic        v_pol;
    } vga_timing_t;

    localparam vga_timing_t VGA_640x480_60 = '{
        h_visible: 16'd640, h_front: 16'd16, h_sync: 16'd96,  h_back: 16'd48,
        v_visible: 16'd480, v_front: 16'd10, v_sync: 16'd2,   v_back: 16'd33,
        h_pol: 1'b0, v_pol: 1'b0};

    localparam vga_timing_t VGA_640x480_75 = '{
        h_visible: 16'd640, h_front: 16'd16, h_sync: 16'd64,  h_back: 16'd120,
        v_visible: 16'd480, v_front: 16'd1,  v_sync: 16'd3,   v_back: 16'd16,
        h_pol: 1'b0, v_pol: 1'b0};

    localparam vga_timing_t SVGA_800x600_60 = '{
        h_visible: 16'd800, h_front: 16'd40, h_sync: 16'd128, h_back: 16'd88,
        v_visible: 16'd600, v_front: 16'd1,  v_sync: 16'd4,   v_back: 16'd23,
        h_pol: 1'b1, v_pol: 1'b1};

    // Full period of one axis in pixels or lines.
    function automatic int unsigned total(input int unsigned visible, input int unsigned front,
                                          input int unsigned sync, input int unsigned back);
        return visible + front + sync + back;
    endfunction

endpackage

// File: rtl/vga_timing_gen_delay.sv
// Enabled shift register that carries the fetch-stage beam state to the display stage.
module vga_delay_line #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             pixel_clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    if (DEPTH < 1) begin : g_bad_depth
        $error("vga_delay_line: DEPTH must be at least 1");
    end

    logic [WIDTH-1:0] stage_q [DEPTH];
    logic [WIDTH-1:0] stage_d [DEPTH];

    always_comb begin : shift_next
        stage_d = stage_q;
        if (enable) begin
            stage_d[0] = din;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                stage_d[i] = stage_q[i-1];
            end
        end
    end

    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                stage_q[i] <= RST_VAL;
            end
        end else begin
            stage_q <= stage_d;
        end
    end

    assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster generator: beam counters, a fetch stage, and a display stage
// delayed LOOKAHEAD enabled cycles so fixed-latency memory reads line up with the beam.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_VISIBLE  = 32'(VGA_640x480_60.h_visible),
    parameter int unsigned H_FRONT    = 32'(VGA_640x480_60.h_front),
    parameter int unsigned H_SYNC     = 32'(VGA_640x480_60.h_sync),
    parameter int unsigned H_BACK     = 32'(VGA_640x480_60.h_back),
    parameter int unsigned V_VISIBLE  = 32'(VGA_640x480_60.v_visible),
    parameter int unsigned V_FRONT    = 32'(VGA_640x480_60.v_front),
    parameter int unsigned V_SYNC     = 32'(VGA_640x480_60.v_sync),
    parameter int unsigned V_BACK     = 32'(VGA_640x480_60.v_back),
    parameter logic        H_SYNC_POL = VGA_640x480_60.h_pol,
    parameter logic        V_SYNC_POL = VGA_640x480_60.v_pol,
    parameter int unsigned LOOKAHEAD  = 2,
    parameter int unsigned CW         = 11
) (
    input  logic          pixel_clk,
    input  logic          rst,
    input  logic          enable,
    output logic [CW-1:0] fetch_x,
    output logic [CW-1:0] fetch_y,
    output logic          fetch_visible,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          is_visible,
    output logic          h_sync,
    output logic          v_sync,
    output logic          line_start,
    output logic          frame_start,
    output logic [7:0]    frame_count
);

    localparam int unsigned H_TOTAL      = total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
    localparam int unsigned V_TOTAL      = total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);
    localparam int unsigned H_SYNC_START = H_VISIBLE + H_FRONT;
    localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC;
    localparam int unsigned V_SYNC_START = V_VISIBLE + V_FRONT;
    localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC;
    localparam int unsigned DL_W         = 2*CW + 13;
    localparam logic [DL_W-1:0] DL_IDLE  = {{(2*CW){1'b0}}, 1'b0, ~H_SYNC_POL, ~V_SYNC_POL,
                                            1'b0, 1'b0, 8'd0};

    if (64'(H_TOTAL) > (64'd1 << CW)) begin : g_bad_h_total
        $error("vga_timing_gen: H_TOTAL does not fit in CW bits");
    end
    if (64'(V_TOTAL) > (64'd1 << CW)) begin : g_bad_v_total
        $error("vga_timing_gen: V_TOTAL does not fit in CW bits");
    end
    if (LOOKAHEAD > 15) begin : g_bad_lookahead
        $error("vga_timing_gen: LOOKAHEAD must be 0..15");
    end

    logic [CW-1:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
    logic [CW-1:0] fetch_x_q, fetch_x_d, fetch_y_q, fetch_y_d;
    logic          fetch_vis_q, fetch_vis_d, fetch_hs_q, fetch_hs_d, fetch_vs_q, fetch_vs_d;
    logic          fetch_ls_q, fetch_ls_d, fetch_fs_q, fetch_fs_d;
    logic [7:0]    fetch_fc_q, fetch_fc_d;
    logic          h_last, v_last, h_in_sync, v_in_sync;

    // Beam counters plus the fetch-stage decode of the current counter position.
    always_comb begin : beam_next
        h_cnt_d     = h_cnt_q;
        v_cnt_d     = v_cnt_q;
        fetch_x_d   = fetch_x_q;
        fetch_y_d   = fetch_y_q;
        fetch_vis_d = fetch_vis_q;
        fetch_hs_d  = fetch_hs_q;
        fetch_vs_d  = fetch_vs_q;
        fetch_ls_d  = fetch_ls_q;
        fetch_fs_d  = fetch_fs_q;
        fetch_fc_d  = fetch_fc_q;
        h_last      = (32'(h_cnt_q) == H_TOTAL - 1);
        v_last      = (32'(v_cnt_q) == V_TOTAL - 1);
        h_in_sync   = (32'(h_cnt_q) >= H_SYNC_START) && (32'(h_cnt_q) < H_SYNC_END);
        v_in_sync   = (32'(v_cnt_q) >= V_SYNC_START) && (32'(v_cnt_q) < V_SYNC_END);
        if (enable) begin
            if (h_last) begin
                h_cnt_d = '0;
                v_cnt_d = v_last ? '0 : v_cnt_q + CW'(1);
            end else begin
                h_cnt_d = h_cnt_q + CW'(1);
            end
            fetch_x_d   = h_cnt_q;
            fetch_y_d   = v_cnt_q;
            fetch_vis_d = (32'(h_cnt_q) < H_VISIBLE) && (32'(v_cnt_q) < V_VISIBLE);
            fetch_hs_d  = h_in_sync ? H_SYNC_POL : ~H_SYNC_POL;
            fetch_vs_d  = v_in_sync ? V_SYNC_POL : ~V_SYNC_POL;
            fetch_ls_d  = (h_cnt_q == '0);
            fetch_fs_d  = (h_cnt_q == '0) && (v_cnt_q == '0);
            // Frame count travels with the beam so it steps on the display frame_start edge.
            fetch_fc_d  = fetch_fc_q + 8'(fetch_fs_d);
        end
    end

    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            h_cnt_q     <= '0;
            v_cnt_q     <= '0;
            fetch_x_q   <= '0;
            fetch_y_q   <= '0;
            fetch_vis_q <= 1'b0;
            fetch_hs_q  <= ~H_SYNC_POL;
            fetch_vs_q  <= ~V_SYNC_POL;
            fetch_ls_q  <= 1'b0;
            fetch_fs_q  <= 1'b0;
            fetch_fc_q  <= 8'd0;
        end else begin
            h_cnt_q     <= h_cnt_d;
            v_cnt_q     <= v_cnt_d;
            fetch_x_q   <= fetch_x_d;
            fetch_y_q   <= fetch_y_d;
            fetch_vis_q <= fetch_vis_d;
            fetch_hs_q  <= fetch_hs_d;
            fetch_vs_q  <= fetch_vs_d;
            fetch_ls_q  <= fetch_ls_d;
            fetch_fs_q  <= fetch_fs_d;
            fetch_fc_q  <= fetch_fc_d;
        end
    end

    logic [DL_W-1:0] fetch_pack_c;
    logic [DL_W-1:0] disp_c;

    assign fetch_pack_c = {fetch_x_q, fetch_y_q, fetch_vis_q, fetch_hs_q, fetch_vs_q,
                           fetch_ls_q, fetch_fs_q, fetch_fc_q};

    if (LOOKAHEAD == 0) begin : g_no_delay
        assign disp_c = fetch_pack_c;
    end else begin : g_delay
        vga_delay_line #(
            .DEPTH   (LOOKAHEAD),
            .WIDTH   (DL_W),
            .RST_VAL (DL_IDLE)
        ) u_delay (
            .pixel_clk (pixel_clk),
            .rst       (rst),
            .enable    (enable),
            .din       (fetch_pack_c),
            .dout      (disp_c)
        );
    end

    assign fetch_x       = fetch_x_q;
    assign fetch_y       = fetch_y_q;
    assign fetch_visible = fetch_vis_q;
    assign {x, y, is_visible, h_sync, v_sync, line_start, frame_start, frame_count} = disp_c;

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised VGA raster timing generator for any mode, replacing the fixed 640x480 generator.
- Generates h/v sync with configurable polarity, plus raster coordinates, visible flag, and line/frame strobes.
- Adds a fetch coordinate stream that leads the display outputs by LOOKAHEAD cycles, so framebuffer/tile RAM reads of known latency line up with the beam.
- A clock enable supports pixel rates below pixel_clk.

Parameters:
H_VISIBLE, 640, visible pixels per line
H_FRONT, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BACK, 48, horizontal back porch (pixels)
V_VISIBLE, 480, visible lines per frame
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BACK, 33, vertical back porch (lines)
H_SYNC_POL, 0, active level of h_sync (0 = active-low)
V_SYNC_POL, 0, active level of v_sync
LOOKAHEAD, 2, cycles fetch outputs lead display outputs (0..15)
CW, 11, coordinate width

Ports:
pixel_clk in 1 pixel clock
rst in 1 synchronous active-high reset
enable in 1 pixel-advance enable; low freezes all state
fetch_x out CW fetch-side horizontal count
fetch_y out CW fetch-side line count
fetch_visible out 1 fetch position is in visible area
x out CW display-side horizontal count
y out CW display-side line count
is_visible out 1 display position is in visible area
h_sync out 1 horizontal sync
v_sync out 1 vertical sync
line_start out 1 one-cycle pulse, display x==0
frame_start out 1 one-cycle pulse, display x==0 and y==0
frame_count out 8 frames started, wraps 255->0

Behaviour:
- Reset is synchronous, active-high, on pixel_clk. It is the only reset.
- H_TOTAL = sum of the H_* parameters; V_TOTAL = sum of the V_* parameters.
- Elaboration fails if H_TOTAL > 2^CW, if V_TOTAL > 2^CW, or if LOOKAHEAD > 15.
- Counters: h_cnt 0..H_TOTAL-1, then 0. On h wrap, v_cnt increments; v_cnt wraps V_TOTAL-1 -> 0. Counters advance only on edges with enable=1.
- Fetch stage:
  - Registered from the counters: fetch_x=h_cnt, fetch_y=v_cnt.
  - fetch_visible = (h_cnt<H_VISIBLE) && (v_cnt<V_VISIBLE).
- Display stage:
  - x, y, is_visible, h_sync, v_sync, line_start and frame_start are the fetch-stage values delayed exactly LOOKAHEAD enabled cycles.
  - With LOOKAHEAD=0 the display outputs equal the fetch outputs in the same cycle.
- Sync decode:
  - h_sync active iff H_VISIBLE+H_FRONT <= h < H_VISIBLE+H_FRONT+H_SYNC.
  - v_sync active iff V_VISIBLE+V_FRONT <= v < V_VISIBLE+V_FRONT+V_SYNC.
  - v_sync therefore changes only together with an h wrap.
- frame_count increments on the same edge that registers frame_start=1.
- Latency: counter value to fetch outputs = 1 cycle; to display outputs = 1+LOOKAHEAD cycles.
- Reset state:
  - h_cnt=v_cnt=0.
  - Fetch and display x/y = 0; is_visible=fetch_visible=0.
  - h_sync=!H_SYNC_POL, v_sync=!V_SYNC_POL; line_start=frame_start=0; frame_count=0.
  - Delay-line stages load these same idle values.
- After rst deasserts with enable=1:
  - First edge: fetch shows (0,0,visible).
  - Edge 1+LOOKAHEAD: display shows (0,0), with frame_start=1 and frame_count=1.
  - Until then the display outputs hold idle values: no spurious sync or strobe.
- enable=0: every register holds, including delay line and frame_count. Strobes stay asserted if they were high; consumers qualify strobes with enable.
- Reset mid-frame: the next edge returns everything to the reset state regardless of enable. There is no partial sync pulse beyond that edge.
- Simultaneous h and v wrap (last pixel of frame): both counters go to 0 on the same edge.

Decomposition:
- Package vga_timing_pkg:
  - vga_timing_t struct (h/v visible, front, sync, back, polarities).
  - Localparam presets VGA_640x480_60, VGA_640x480_75 and SVGA_800x600_60 (tinyvga values).
  - Function total(...) used for elaboration checks.
- Sub-module vga_delay_line: parametrised DEPTH x WIDTH shift register with enable and per-stage reset value. It carries {x, y, visible, h_sync, v_sync, line_start, frame_start}.

Test Plan:
- Small mode H=8/2/3/1, V=4/1/2/1, LOOKAHEAD=2, positive polarities. Release reset with enable=1 -> frame_start at edge 3; next frame_start exactly 14*8=112 cycles later; frame_count 1 then 2.
- Same mode, check sync positions -> h_sync high exactly for x=10..12 on every line; v_sync high exactly for y=5..6, all 14 cycles of each of those lines; is_visible only for x<8 && y<4.
- Alignment check -> for every enabled cycle, display (x,y) equals fetch (x,y) from 2 enabled cycles earlier; repeat with LOOKAHEAD=0 (identical) and LOOKAHEAD=5.
- enable toggled 1-0-0-1 pseudo-randomly -> outputs frozen while low; sequence of (x,y) over enabled cycles is identical to the free-running run.
- Assert rst at x=11, y=5 (both syncs active) -> next edge: h_sync=v_sync=0 (inactive level for positive polarity), x=y=0, is_visible=0; frame_count=0.
- Default 640x480 parameters, active-low polarities -> h_sync low 96 cycles per 800-cycle line; v_sync low for 2 lines out of 525; frame_count wraps 255->0 after 256 frames.
